// File: rtl/uart_byte_tx.sv
// uart_byte_tx: accepts a byte over valid/ready and shifts it out LSB-first as a UART frame on tx.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits (parameter PARITY_ODD selects odd).
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
  , parameter int PARITY_ODD = 0
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       tx_busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
`endif

  logic [2:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          tx_reg;
  logic          baud_done;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign in_ready  = (state == IDLE) && !rst;
  assign tx_busy   = (state != IDLE);
  assign tx        = tx_reg;

  // bit_cnt indexes data bits in DATA and is reused to count stop bits in STOP
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      if (state != IDLE) begin
        baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          tx_reg <= 1'b1;
          if (in_valid && in_ready) begin
            state     <= START;
            shift_reg <= in_data;
            tx_reg    <= 1'b0;
            bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^(in_data & DATA_MASK)) ^ 1'(PARITY_ODD);
`endif
          end
        end
        START: begin
          if (baud_done) begin
            state  <= DATA;
            tx_reg <= shift_reg[0];
          end
        end
        DATA: begin
          if (baud_done) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx_reg  <= parity_bit;
`else
              state   <= STOP;
              tx_reg  <= 1'b1;
`endif
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx_reg    <= shift_reg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            state  <= STOP;
            tx_reg <= 1'b1;
          end
        end
`endif
        STOP: begin
          tx_reg <= 1'b1;
          if (baud_done) begin
            if (bit_cnt == STOP_LAST) begin
              state   <= IDLE;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          tx_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: stimulus pushes expected bytes into per-instance queues; a line monitor decodes tx frames and compares.
// Instance 0 is 8 data / 1 stop, instance 1 is 7 data / 2 stop, both at 4 clocks per bit.
`timescale 1ns/1ps
module tb_uart_byte_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME0 = (1 + 8 + PBITS + 1) * CPB;
  localparam int FRAME1 = (1 + 7 + PBITS + 2) * CPB;

  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1;
  logic in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic [7:0] in_data0 = 8'h00, in_data1 = 8'h00;
  logic in_ready0, in_ready1, tx0, tx1, busy0, busy1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef UART_TX_PARITY_EN
  uart_byte_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst0), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .tx(tx0), .tx_busy(busy0));
  uart_byte_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst(rst1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx(tx1), .tx_busy(busy1));
`else
  uart_byte_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst0), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .tx(tx0), .tx_busy(busy0));
  uart_byte_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx(tx1), .tx_busy(busy1));
`endif

  function automatic logic line_of(input int s);
    return (s == 0) ? tx0 : tx1;
  endfunction

  function automatic logic busy_of(input int s);
    return (s == 0) ? busy0 : busy1;
  endfunction

  function automatic logic ready_of(input int s);
    return (s == 0) ? in_ready0 : in_ready1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Present a byte and wait for the accepting edge; returns at the negedge after it with the accept cycle.
  task automatic applyStimulus(input int s, input logic [7:0] d, input bit push,
                               input logic [7:0] expv, output int acc);
    int n;
    n = 0;
    acc = -1;
    @(negedge clk);
    if (s == 0) begin in_data0 = d; in_valid0 = 1'b1; end
    else        begin in_data1 = d; in_valid1 = 1'b1; end
    while (ready_of(s) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready_of(s) !== 1'b1) begin
      checkOutput($sformatf("accept_timeout_%0d", s), 0, 1);
    end else begin
      @(posedge clk);
      if (push) begin
        if (s == 0) exp_q0.push_back(expv);
        else        exp_q1.push_back(expv);
      end
      @(negedge clk);
      acc = cyc;
    end
  endtask

  task automatic waitIdle(input int s);
    int n;
    n = 0;
    while (ready_of(s) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready_of(s) !== 1'b1) checkOutput($sformatf("idle_timeout_%0d", s), 0, 1);
  endtask

  // Decode one frame per falling edge of an idle line; a drop of tx_busy mid-frame means it was reset away.
  task automatic monitor(input int s);
    int nb, ns, total;
    logic prev, v, stop_ok;
    logic bits [0:15];
    logic [7:0] got, expv;
    bit aborted, stable;
    nb = (s == 0) ? 8 : 7;
    ns = (s == 0) ? 1 : 2;
    total = 1 + nb + PBITS + ns;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && line_of(s) === 1'b0) begin
        aborted = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < total * CPB; i++) begin
          if (i > 0) @(negedge clk);
          if (busy_of(s) !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          v = line_of(s);
          if (i % CPB == 0) bits[i / CPB] = v;
          else if (v !== bits[i / CPB]) stable = 1'b0;
        end
        if (!aborted) begin
          got = 8'h00;
          for (int b = 0; b < nb; b++) got[b] = bits[1 + b];
          stop_ok = 1'b1;
          for (int b = 0; b < ns; b++) if (bits[1 + nb + PBITS + b] !== 1'b1) stop_ok = 1'b0;
          if ((s == 0 && exp_q0.size() == 0) || (s == 1 && exp_q1.size() == 0)) begin
            checkOutput($sformatf("unexpected_frame_%0d", s), {24'd0, got}, 32'hFFFF_FFFF);
          end else begin
            expv = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            checkOutput($sformatf("frame%0d_start", s), {31'd0, bits[0]}, 0);
            checkOutput($sformatf("frame%0d_data", s), {24'd0, got}, {24'd0, expv});
            checkOutput($sformatf("frame%0d_stop", s), {31'd0, stop_ok}, 1);
            checkOutput($sformatf("frame%0d_bit_stable", s), {31'd0, stable}, 1);
`ifdef UART_TX_PARITY_EN
            checkOutput($sformatf("frame%0d_parity", s), {31'd0, bits[1 + nb]},
                        {31'd0, (^expv) ^ (s == 1)});
`endif
          end
        end
      end
      prev = line_of(s);
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
    join
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc_a, acc_b, n, seen;

    // Reset state, with in_ready held low while rst is asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tx", tx0, 1);
    checkOutput("reset_busy", busy0, 0);
    checkOutput("ready_during_rst", in_ready0, 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    #1;
    checkOutput("ready_after_rst", in_ready0, 1);
    checkOutput("reset_tx_inst1", tx1, 1);

    // 0x55: start bit on the edge after acceptance, next accept possible one frame plus one cycle later
    applyStimulus(0, 8'h55, 1'b1, 8'h55, acc_a);
    in_valid0 = 1'b0;
    checkOutput("latency_tx", tx0, 0);
    checkOutput("latency_busy", busy0, 1);
    checkOutput("latency_ready", in_ready0, 0);
    n = 0;
    while (in_ready0 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_gap_55", cyc + 1 - acc_a, FRAME0 + 1);

    // Back-to-back with in_valid held high
    applyStimulus(0, 8'hA5, 1'b1, 8'hA5, acc_a);
    applyStimulus(0, 8'h3C, 1'b1, 8'h3C, acc_b);
    in_valid0 = 1'b0;
    checkOutput("b2b_accept_gap", acc_b - acc_a, FRAME0 + 1);
    waitIdle(0);

    // Byte offered while busy must be ignored entirely
    applyStimulus(0, 8'h96, 1'b1, 8'h96, acc_a);
    in_valid0 = 1'b0;
    repeat (10) @(negedge clk);
    in_data0 = 8'hFF;
    in_valid0 = 1'b1;
    checkOutput("ready_low_midframe", in_ready0, 0);
    @(negedge clk);
    in_valid0 = 1'b0;
    in_data0 = 8'h00;
    waitIdle(0);
    seen = 0;
    repeat (FRAME0) begin
      @(negedge clk);
      if (busy0 !== 1'b0) seen++;
    end
    checkOutput("no_extra_frame", seen, 0);

    // Reset during data bit 3 of 0x00 truncates the frame
    applyStimulus(0, 8'h00, 1'b0, 8'h00, acc_a);
    in_valid0 = 1'b0;
    repeat (17) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    #1;
    checkOutput("midreset_tx", tx0, 1);
    checkOutput("midreset_busy", busy0, 0);
    checkOutput("midreset_ready", in_ready0, 1);

    // rst and in_valid together: reset wins
    @(negedge clk);
    rst0 = 1'b1;
    in_data0 = 8'h5A;
    in_valid0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    in_valid0 = 1'b0;
    checkOutput("rst_beats_valid_busy", busy0, 0);
    checkOutput("rst_beats_valid_tx", tx0, 1);

    applyStimulus(0, 8'h81, 1'b1, 8'h81, acc_a);
    in_valid0 = 1'b0;
    waitIdle(0);

    // 7 data bits, 2 stop bits: MSB of 0x80 never appears on the line
    applyStimulus(1, 8'h7F, 1'b1, 8'h7F, acc_a);
    applyStimulus(1, 8'h80, 1'b1, 8'h00, acc_b);
    in_valid1 = 1'b0;
    checkOutput("inst1_accept_gap", acc_b - acc_a, FRAME1 + 1);
    waitIdle(1);

`ifdef UART_TX_PARITY_EN
    applyStimulus(0, 8'h07, 1'b1, 8'h07, acc_a);
    in_valid0 = 1'b0;
    applyStimulus(1, 8'h07, 1'b1, 8'h07, acc_b);
    in_valid1 = 1'b0;
    waitIdle(0);
    waitIdle(1);
`endif

    repeat (2 * FRAME0) @(negedge clk);
    checkOutput("queue0_drained", exp_q0.size(), 0);
    checkOutput("queue1_drained", exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
